// File: rtl/machine_timer_if.sv
// Data-bus slave port of the machine timer. Master holds bus_valid with addr/data/we/be
// stable until it sees the one-cycle bus_ready pulse, then drops valid for at least one cycle.
interface machine_timer_if;
  logic        bus_valid;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/machine_timer.sv
// CLINT-style machine timer: 64-bit mtime/mtimecmp, msip, and the registered
// timer/software interrupt levels feeding mip[7]/mip[3].
module machine_timer #(
  parameter int unsigned TICK_DIV = 27
) (
  input  logic           clock,
  input  logic           reset,
  machine_timer_if.slave bus,
  output logic           timer_interrupt,
  output logic           software_interrupt,
  output logic           dbg_state_o
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  // Word offsets (byte offset >> 2)
  localparam logic [13:0] A_MSIP    = 14'h0000;
  localparam logic [13:0] A_CMP_LO  = 14'h1000;
  localparam logic [13:0] A_CMP_HI  = 14'h1001;
  localparam logic [13:0] A_TIME_LO = 14'h2FFE;
  localparam logic [13:0] A_TIME_HI = 14'h2FFF;

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e      state_q;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic        msip_q, msip_d;
  logic [63:0] cmp_q, cmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] presc_q, presc_d;
  logic        tip_q, sip_q;

  logic        tick;
  logic        accept;
  logic        wr_en;
  logic [13:0] word;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  assign word             = bus.bus_addr[15:2];
  assign unused_addr_bits = ^bus.bus_addr[1:0];
  assign tick             = (presc_q == PRESC_LAST);
  assign accept           = (state_q == S_IDLE) && bus.bus_valid;
  assign wr_en            = accept && bus.bus_we;

  always_comb begin
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    rdata_d = '0;
    if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + 16'd1;
      mtime_d = mtime_q;
    end

    // An mtime write overrides the tick: other half frozen, prescaler restarts
    if (accept) begin
      case (word)
        A_MSIP: begin
          rdata_d = {31'd0, msip_q};
          if (wr_en && bus.bus_be[0]) msip_d = bus.bus_wdata[0];
        end
        A_CMP_LO: begin
          rdata_d = cmp_q[31:0];
          if (wr_en) cmp_d[31:0] = merge_bytes(cmp_q[31:0], bus.bus_wdata, bus.bus_be);
        end
        A_CMP_HI: begin
          rdata_d = cmp_q[63:32];
          if (wr_en) cmp_d[63:32] = merge_bytes(cmp_q[63:32], bus.bus_wdata, bus.bus_be);
        end
        A_TIME_LO: begin
          rdata_d = mtime_q[31:0];
          if (wr_en) begin
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus.bus_wdata, bus.bus_be)};
            presc_d = '0;
          end
        end
        A_TIME_HI: begin
          rdata_d = mtime_q[63:32];
          if (wr_en) begin
            mtime_d = {merge_bytes(mtime_q[63:32], bus.bus_wdata, bus.bus_be), mtime_q[31:0]};
            presc_d = '0;
          end
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
      msip_q  <= 1'b0;
      cmp_q   <= '1;
      mtime_q <= '0;
      presc_q <= '0;
      tip_q   <= 1'b0;
      sip_q   <= 1'b0;
    end else begin
      msip_q  <= msip_d;
      cmp_q   <= cmp_d;
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      tip_q   <= (mtime_q >= cmp_q);
      sip_q   <= msip_q;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            rdata_q <= rdata_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.bus_ready       = ready_q;
  assign bus.bus_rdata       = rdata_q;
  assign timer_interrupt     = tip_q;
  assign software_interrupt  = sip_q;
  assign dbg_state_o         = (state_q == S_RESP);

endmodule
